ycc_stream_ctrl: RTL
====================

Name: ycc_stream_ctrl

Overview:
- Flow controller wrapped around the fixed-latency rgb2ycrcb colour converter.
- Accepts RGB pixels on a valid/ready stream and issues them to the converter, which cannot stall.
- Uses credits so every in-flight result is guaranteed a slot in a local output FIFO.
- Presents YCbCr pixels on a valid/ready stream tagged with 8x8 block and frame boundaries for the downstream block-buffer stage.

Parameters:
- LATENCY, 3: converter enable-to-enable_out delay in cycles.
- FIFO_DEPTH, 8: output FIFO entries; power of two; must be >= LATENCY+2 for one pixel per cycle.
- NUM_BLOCKS, 4800: 8x8 blocks per frame (640x480 default).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  RGB pixel valid
- s_ready  out  1  controller accepts pixel
- s_data  in  24  {B,G,R} pixel
- abort  in  1  one-cycle frame abort pulse
- conv_enable  out  1  to converter enable
- conv_data_in  out  24  to converter data_in
- conv_enable_out  in  1  from converter enable_out
- conv_data_out  in  24  from converter data_out, {Cr,Cb,Y}
- m_valid  out  1  YCbCr pixel valid
- m_ready  in  1  downstream accepts
- m_data  out  24  {Cr,Cb,Y}
- m_sof  out  1  first pixel of frame
- m_eob  out  1  64th pixel of a block
- m_eof  out  1  last pixel of frame
- busy  out  1  pixels in flight or buffered
- err_ovf  out  1  sticky: result arrived with FIFO full

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. The converter shares rst.
- Reset values:
  - all outputs 0 except s_ready, which is 0 during reset and 1 on the first cycle after it;
  - in_flight, fifo_count, pix_cnt, blk_cnt, drop_cnt all 0.
- Credit rule:
  - occ = in_flight + fifo_count, using registered values only (no combinational path from m_ready).
  - s_ready = !rst && !abort && occ < FIFO_DEPTH.
- Issue:
  - On s_valid && s_ready, drive conv_enable=1 and conv_data_in=s_data combinationally in the same cycle.
  - in_flight increments in that cycle.
- Return:
  - conv_enable_out=1 decrements in_flight.
  - If drop_cnt==0, conv_data_out is pushed into the FIFO; otherwise the result is discarded and drop_cnt decrements.
  - Simultaneous issue and return leave in_flight unchanged.
- Overflow: a push with fifo_count==FIFO_DEPTH cannot occur under the credit rule. If it does, set err_ovf (cleared only by rst) and drop the data.
- Output:
  - m_valid = fifo_count != 0; m_data is the FIFO head.
  - Pop on m_valid && m_ready. Push and pop in the same cycle on a non-empty FIFO leave the count unchanged.
  - Push into an empty FIFO appears on m_valid the next cycle.
- Tag counters advance on each pop:
  - pix_cnt runs 0..63 and wraps.
  - blk_cnt runs 0..NUM_BLOCKS-1 and wraps to 0 after eof.
  - m_sof = (pix_cnt==0 && blk_cnt==0).
  - m_eob = (pix_cnt==63).
  - m_eof = m_eob && blk_cnt==NUM_BLOCKS-1.
  - Tags are stable while m_valid && !m_ready.
- Latency: s-accept to m_valid = LATENCY+1 cycles with an empty FIFO.
- Throughput: 1 pixel/cycle sustained when m_ready=1 and FIFO_DEPTH >= LATENCY+2.
- Abort (single-cycle pulse):
  - same cycle: s_ready=0, no issue;
  - next edge: FIFO flushed (count 0), pix_cnt=blk_cnt=0;
  - drop_cnt = in_flight, minus 1 if a return arrives in the abort cycle;
  - that abort-cycle return is itself discarded.
  - in_flight is not cleared; it drains through normal returns.
  - Abort while drop_cnt>0: drop_cnt is reloaded the same way.
- busy = (in_flight != 0) || (fifo_count != 0).
- Width rules:
  - in_flight and drop_cnt are clog2(FIFO_DEPTH+1) bits;
  - pix_cnt is 6 bits; blk_cnt is clog2(NUM_BLOCKS) bits.
- Elaboration: assert that FIFO_DEPTH is a power of two and FIFO_DEPTH > LATENCY.

Decomposition:
- Shared package jpeg_pkg:
  - typedefs: pixel_rgb_t and pixel_ycc_t (24-bit packed);
  - constants: BLK_PIX=64, CONV_LATENCY=3.
- One sub-module, sync_fifo:
  - parameterised width/depth, synchronous reset, flush input;
  - outputs: count, full, empty; ports for push/pop.
- Credit, drop and tag counters live in ycc_stream_ctrl.

Test Plan:
- Reset, then s_data=0x0000FF held valid with m_ready=1, and a converter model with LATENCY=3 → first m_valid 4 cycles after the first accept, m_data=0xFF554C, m_sof=1. Thereafter 1 pixel/cycle.
- m_ready=0, continuous s_valid, FIFO_DEPTH=8 → exactly 8 pixels accepted, then s_ready=0 and held. err_ovf stays 0. Release m_ready → all 8 delivered in order.
- Stream 128 pixels with NUM_BLOCKS=2 → m_eob on pops 64 and 128; m_eof on pop 128 only. Pixel 129 has m_sof=1.
- Random m_ready at 50% over 1000 pixels → output order equals input order, no loss, err_ovf=0, busy=0 after drain.
- Issue 3 pixels, then abort on the cycle the first result returns with 2 words already in the FIFO → FIFO empties, remaining 2 in-flight results are dropped (drop_cnt 2→0), and the next accepted pixel emerges with m_sof=1.
- Assert rst mid-stream with in_flight=3 → next cycle all counters and outputs 0. s_ready=1 one cycle after rst deasserts, and no stale pixel appears on m_valid.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared pixel types and constants for the JPEG front-end stages.
package jpeg_pkg;

  localparam int unsigned PIX_W        = 24;
  localparam int unsigned BLK_PIX      = 64;
  localparam int unsigned CONV_LATENCY = 3;

  // RGB pixel as carried on the input stream: {B,G,R}
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_rgb_t;

  // YCbCr pixel as produced by the converter: {Cr,Cb,Y}
  typedef struct packed {
    logic [7:0] cr;
    logic [7:0] cb;
    logic [7:0] y;
  } pixel_ycc_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; pushes into a full FIFO are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; flush discards everything held
  always_comb begin
    wr_en    = push_i && !full_o;
    rd_en    = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ycc_stream_ctrl.sv
// Credit-based flow controller around the non-stallable rgb2ycrcb converter,
// with an output FIFO and 8x8 block / frame tagging of the result stream.
module ycc_stream_ctrl
  import jpeg_pkg::*;
#(
  parameter int unsigned LATENCY    = CONV_LATENCY,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned NUM_BLOCKS = 4800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  pixel_rgb_t s_data,
  input  logic       abort,
  output logic       conv_enable,
  output pixel_rgb_t conv_data_in,
  input  logic       conv_enable_out,
  input  pixel_ycc_t conv_data_out,
  output logic       m_valid,
  input  logic       m_ready,
  output pixel_ycc_t m_data,
  output logic       m_sof,
  output logic       m_eob,
  output logic       m_eof,
  output logic       busy,
  output logic       err_ovf
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(BLK_PIX);
  localparam int unsigned BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH <= LATENCY) begin : g_cfg_check
    $error("ycc_stream_ctrl: FIFO_DEPTH must be a power of two greater than LATENCY");
  end

  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          err_ovf_q, err_ovf_d;

  logic [CW:0]   occ;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [PIX_W-1:0] fifo_head;
  logic          issue, ret, push_req, pop;
  logic          last_pix, last_blk;

  // Credit check uses registered occupancy only, so m_ready never reaches s_ready
  always_comb begin
    occ          = (CW+1)'(in_flight_q) + (CW+1)'(fifo_count);
    s_ready      = !rst && !abort && (occ < (CW+1)'(FIFO_DEPTH));
    issue        = s_valid && s_ready;
    conv_enable  = issue;
    conv_data_in = issue ? s_data : '0;
    ret          = conv_enable_out;
    push_req     = ret && (drop_cnt_q == '0) && !abort;
    m_valid      = !fifo_empty;
    pop          = m_valid && m_ready && !abort;
    m_data       = m_valid ? pixel_ycc_t'(fifo_head) : '0;
    last_pix     = (pix_cnt_q == PW'(BLK_PIX - 1));
    last_blk     = (blk_cnt_q == BW'(NUM_BLOCKS - 1));
    m_sof        = m_valid && (pix_cnt_q == '0) && (blk_cnt_q == '0);
    m_eob        = m_valid && last_pix;
    m_eof        = m_valid && last_pix && last_blk;
    busy         = (in_flight_q != '0) || (fifo_count != '0);
    err_ovf      = err_ovf_q;
  end

  // Next-state for credit, drop, tag and error registers
  always_comb begin
    in_flight_d = in_flight_q + CW'(issue) - CW'(ret);
    drop_cnt_d  = drop_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    err_ovf_d   = err_ovf_q || (push_req && fifo_full);
    if (abort) begin
      drop_cnt_d = in_flight_q - CW'(ret);
      pix_cnt_d  = '0;
      blk_cnt_d  = '0;
    end else begin
      if (ret && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (pop) begin
        pix_cnt_d = pix_cnt_q + PW'(1);
        if (last_pix) blk_cnt_d = last_blk ? '0 : blk_cnt_q + BW'(1);
      end
    end
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      blk_cnt_q   <= '0;
      err_ovf_q   <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (abort),
    .push_i  (push_req),
    .data_i  (conv_data_out),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
